// File: rtl/seq_detect_pkg.sv
// Shared limits and the elaboration-time next-state rule for seq_detect_param.
package seq_detect_pkg;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 32;

    // Longest prefix of the pattern that is a suffix of (first p pattern bits, then x).
    // pattern[pat_w-1] is the first bit received. From a full match the pattern itself
    // is the prefix source when overlapping, otherwise the search restarts from empty.
    function automatic int next_state(input int p, input logic x,
                                      input logic [PAT_W_MAX-1:0] pattern,
                                      input int pat_w, input int overlap);
        logic [PAT_W_MAX:0] s;
        int                 base;
        int                 len;
        int                 best;
        logic               ok;
        if (p >= pat_w && overlap == 0) base = 0;
        else                            base = p;
        len = base + 1;
        s   = '0;
        for (int i = 0; i < PAT_W_MAX; i++) begin
            if (i < base) s[5'(i)] = pattern[4'(pat_w - 1 - i)];
        end
        s[5'(base)] = x;
        best = 0;
        for (int j = 1; j <= PAT_W_MAX; j++) begin
            if (j <= len && j <= pat_w) begin
                ok = 1'b1;
                for (int i = 0; i < PAT_W_MAX; i++) begin
                    if (i < j && s[5'(len - j + i)] != pattern[4'(pat_w - 1 - i)]) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_detect_param_match_cnt.sv
// Saturating, enable-gated match counter with synchronous active-high clear.
module seq_match_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count enabled events, parking at all-ones instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_clr)                     r_cnt <= '0;
        else if (i_en && r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector (Moore), KMP-style progress tracking.
// Optional feature macro: SEQDET_MATCH_CNT_EN enables the match counter;
// without it match_cnt is tied to zero.
//
// state            | meaning
// -----------------+------------------------------------------------
// ST_IDLE (P=0)    | no pattern prefix matched
// P=1..PAT_W-1     | last P consumed bits equal first P pattern bits
// ST_FULL (P=PAT_W)| complete match, Z high
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic                       Clk,
    input  logic                       Clr,
    input  logic                       X,
    input  logic                       X_vld,
    output logic                       Z,
    output logic [$clog2(PAT_W+1)-1:0] prog,
    output logic [CNT_W-1:0]           match_cnt
);

    localparam int                      PW      = $clog2(PAT_W + 1);
    localparam logic [PW-1:0]           ST_IDLE = '0;
    localparam logic [PW-1:0]           ST_FULL = PW'(PAT_W);
    localparam logic [PAT_W_MAX-1:0]    PAT16   = PAT_W_MAX'(PATTERN);

    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
        $error("seq_detect_param: PAT_W out of range 2..16");
    end
    if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
        $error("seq_detect_param: CNT_W out of range 1..32");
    end

    logic [PW-1:0] w_nxt0 [0:PAT_W];
    logic [PW-1:0] w_nxt1 [0:PAT_W];
    logic [PW-1:0] w_p_next;
    logic [PW-1:0] r_p;

    // Next-state table, fully resolved from the parameters at elaboration.
    for (genvar g = 0; g <= PAT_W; g++) begin : g_tbl
        localparam logic [PW-1:0] NXT0 = PW'(next_state(g, 1'b0, PAT16, PAT_W, OVERLAP));
        localparam logic [PW-1:0] NXT1 = PW'(next_state(g, 1'b1, PAT16, PAT_W, OVERLAP));
        assign w_nxt0[g] = NXT0;
        assign w_nxt1[g] = NXT1;
    end

    assign w_p_next = X ? w_nxt1[r_p] : w_nxt0[r_p];

    // Progress register: clear dominates, otherwise advance only on valid bits.
    always_ff @(posedge Clk) begin
        if (Clr)        r_p <= ST_IDLE;
        else if (X_vld) r_p <= w_p_next;
    end

    assign Z    = (r_p == ST_FULL);
    assign prog = r_p;

`ifdef SEQDET_MATCH_CNT_EN
    logic w_hit;
    assign w_hit = X_vld && (w_p_next == ST_FULL);

    seq_match_cnt #(.CNT_W(CNT_W)) u_match_cnt (
        .i_clk (Clk),
        .i_clr (Clr),
        .i_en  (w_hit),
        .o_cnt (match_cnt)
    );
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: four differently parameterised instances,
// directed vector table plus randomized streams against a history-based model.
module tb_seq_detect_param;

`ifdef SEQDET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam int         PWA  [4] = '{3, 3, 6, 2};
    localparam logic [15:0] PATA[4] = '{16'b101, 16'b101, 16'b101101, 16'b11};
    localparam int         OVLA [4] = '{1, 0, 1, 1};
    localparam int         CWA  [4] = '{8, 8, 8, 2};

    logic Clk;
    logic clr [4];
    logic vld [4];
    logic xb  [4];
    logic zo  [4];
    logic [1:0] p0, p1, p3;
    logic [2:0] p2;
    logic [7:0] c0, c1, c2;
    logic [1:0] c3;

    int checks = 0;
    int errors = 0;

    seq_detect_param #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(8)) u0 (
        .Clk(Clk), .Clr(clr[0]), .X(xb[0]), .X_vld(vld[0]), .Z(zo[0]), .prog(p0), .match_cnt(c0));
    seq_detect_param #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(0), .CNT_W(8)) u1 (
        .Clk(Clk), .Clr(clr[1]), .X(xb[1]), .X_vld(vld[1]), .Z(zo[1]), .prog(p1), .match_cnt(c1));
    seq_detect_param #(.PAT_W(6), .PATTERN(6'b101101), .OVERLAP(1), .CNT_W(8)) u2 (
        .Clk(Clk), .Clr(clr[2]), .X(xb[2]), .X_vld(vld[2]), .Z(zo[2]), .prog(p2), .match_cnt(c2));
    seq_detect_param #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2)) u3 (
        .Clk(Clk), .Clr(clr[3]), .X(xb[3]), .X_vld(vld[3]), .Z(zo[3]), .prog(p3), .match_cnt(c3));

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        int   d;
        logic c;
        logic v;
        logic x;
        int   p;
        int   z;
        int   cnt;
    } vec_t;

    typedef struct {
        logic [31:0] hist;
        int          len;
        int          p;
        int          cnt;
    } mdl_t;

    // Model: match progress is the longest pattern prefix that ends the consumed
    // history; in non-overlap mode the history is discarded after a full match.
    function automatic mdl_t mstep(mdl_t m, int d, logic c, logic v, logic x);
        mdl_t r;
        int   best;
        bit   ok;
        r = m;
        if (c) begin
            r.hist = '0; r.len = 0; r.p = 0; r.cnt = 0;
            return r;
        end
        if (!v) return r;
        if (OVLA[d] == 0 && m.p == PWA[d]) begin
            r.hist = '0; r.len = 0;
        end
        r.hist = {r.hist[30:0], x};
        if (r.len < 32) r.len++;
        best = 0;
        for (int j = 1; j <= PWA[d] && j <= r.len; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++)
                if (r.hist[j - 1 - i] != PATA[d][PWA[d] - 1 - i]) ok = 1'b0;
            if (ok) best = j;
        end
        r.p = best;
        if (best == PWA[d] && r.cnt < (1 << CWA[d]) - 1) r.cnt++;
        return r;
    endfunction

    task automatic read_dut(input int d, output int p, output int z, output int c);
        case (d)
            0:       begin p = int'(p0); c = int'(c0); end
            1:       begin p = int'(p1); c = int'(c1); end
            2:       begin p = int'(p2); c = int'(c2); end
            default: begin p = int'(p3); c = int'(c3); end
        endcase
        z = int'(zo[d]);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int d, input int ep, input int ez, input int ec);
        int ap, az, ac;
        read_dut(d, ap, az, ac);
        check($sformatf("%s d%0d prog", tag, d), ap, ep);
        check($sformatf("%s d%0d Z", tag, d), az, ez);
        check($sformatf("%s d%0d cnt", tag, d), ac, CNT_EN ? ec : 0);
    endtask

    // Drive one instance for one edge; all others hold (no clear, no valid).
    task automatic apply1(input int d, input logic c, input logic v, input logic x);
        @(negedge Clk);
        for (int k = 0; k < 4; k++) begin
            clr[k] = 1'b0; vld[k] = 1'b0; xb[k] = 1'b0;
        end
        clr[d] = c; vld[d] = v; xb[d] = x;
        @(posedge Clk);
        #1;
    endtask

    vec_t vt[$];

    function automatic vec_t mk(int d, logic c, logic v, logic x, int p, int z, int cnt);
        vec_t r;
        r.d = d; r.c = c; r.v = v; r.x = x; r.p = p; r.z = z; r.cnt = cnt;
        return r;
    endfunction

    initial begin
        mdl_t m [4];
        int   ap, az, ac;

        for (int k = 0; k < 4; k++) begin
            clr[k] = 1'b0; vld[k] = 1'b0; xb[k] = 1'b0;
        end

        // 101 overlapping: 1,0,1,0,1
        vt.push_back(mk(0, 0, 1, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 2, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 3, 1, 1));
        vt.push_back(mk(0, 0, 1, 0, 2, 0, 1));
        vt.push_back(mk(0, 0, 1, 1, 3, 1, 2));
        // 101 non-overlapping: same stream
        vt.push_back(mk(1, 0, 1, 1, 1, 0, 0));
        vt.push_back(mk(1, 0, 1, 0, 2, 0, 0));
        vt.push_back(mk(1, 0, 1, 1, 3, 1, 1));
        vt.push_back(mk(1, 0, 1, 0, 0, 0, 1));
        vt.push_back(mk(1, 0, 1, 1, 1, 0, 1));
        // 101101 overlapping: 1,0,1,1,0,1,1,0,1
        vt.push_back(mk(2, 0, 1, 1, 1, 0, 0));
        vt.push_back(mk(2, 0, 1, 0, 2, 0, 0));
        vt.push_back(mk(2, 0, 1, 1, 3, 0, 0));
        vt.push_back(mk(2, 0, 1, 1, 4, 0, 0));
        vt.push_back(mk(2, 0, 1, 0, 5, 0, 0));
        vt.push_back(mk(2, 0, 1, 1, 6, 1, 1));
        vt.push_back(mk(2, 0, 1, 1, 4, 0, 1));
        vt.push_back(mk(2, 0, 1, 0, 5, 0, 1));
        vt.push_back(mk(2, 0, 1, 1, 6, 1, 2));
        // valid gaps between bits 2 and 3, then hold while Z=1
        vt.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 2, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 2, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 2, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 2, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 3, 1, 1));
        vt.push_back(mk(0, 0, 0, 0, 3, 1, 1));
        vt.push_back(mk(0, 0, 0, 1, 3, 1, 1));
        // clear mid-pattern (overriding a valid bit), then while Z=1
        vt.push_back(mk(0, 0, 1, 0, 2, 0, 1));
        vt.push_back(mk(0, 1, 1, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 2, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 3, 1, 1));
        vt.push_back(mk(0, 1, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 2, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 3, 1, 1));
        // pattern 11, CNT_W=2: six 1s saturate the counter at 3
        vt.push_back(mk(3, 0, 1, 1, 1, 0, 0));
        vt.push_back(mk(3, 0, 1, 1, 2, 1, 1));
        vt.push_back(mk(3, 0, 1, 1, 2, 1, 2));
        vt.push_back(mk(3, 0, 1, 1, 2, 1, 3));
        vt.push_back(mk(3, 0, 1, 1, 2, 1, 3));
        vt.push_back(mk(3, 0, 1, 1, 2, 1, 3));
        vt.push_back(mk(3, 0, 0, 0, 2, 1, 3));
        vt.push_back(mk(3, 0, 1, 0, 0, 0, 3));

        // Reset all instances together.
        @(negedge Clk);
        for (int k = 0; k < 4; k++) begin
            clr[k] = 1'b1; vld[k] = 1'b1; xb[k] = 1'b1;
        end
        @(posedge Clk);
        #1;
        for (int k = 0; k < 4; k++) check_all("reset", k, 0, 0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            apply1(vt[i].d, vt[i].c, vt[i].v, vt[i].x);
            check_all($sformatf("vec%0d", i), vt[i].d, vt[i].p, vt[i].z, vt[i].cnt);
        end

        // Non-overlapping 101 on 1,0,1,1,0,1: two disjoint matches.
        apply1(1, 1'b1, 1'b0, 1'b0);
        apply1(1, 1'b0, 1'b1, 1'b1);
        apply1(1, 1'b0, 1'b1, 1'b0);
        apply1(1, 1'b0, 1'b1, 1'b1);
        check_all("novl_m1", 1, 3, 1, 1);
        apply1(1, 1'b0, 1'b1, 1'b1);
        check_all("novl_restart", 1, 1, 0, 1);
        apply1(1, 1'b0, 1'b1, 1'b0);
        apply1(1, 1'b0, 1'b1, 1'b1);
        check_all("novl_m2", 1, 3, 1, 2);

        // Randomized streams on all four instances against the model.
        @(negedge Clk);
        for (int k = 0; k < 4; k++) begin
            clr[k] = 1'b1; vld[k] = 1'b0; xb[k] = 1'b0;
            m[k] = mstep(m[k], k, 1'b1, 1'b0, 1'b0);
        end
        @(posedge Clk);
        #1;
        for (int t = 0; t < 600; t++) begin
            @(negedge Clk);
            for (int k = 0; k < 4; k++) begin
                clr[k] = ($urandom_range(0, 49) == 0);
                vld[k] = ($urandom_range(0, 3) != 0);
                xb[k]  = (k == 3) ? ($urandom_range(0, 4) != 0) : 1'($urandom_range(0, 1));
                m[k]   = mstep(m[k], k, clr[k], vld[k], xb[k]);
            end
            @(posedge Clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                read_dut(k, ap, az, ac);
                check($sformatf("rnd%0d d%0d prog", t, k), ap, m[k].p);
                check($sformatf("rnd%0d d%0d Z", t, k), az, int'(m[k].p == PWA[k]));
                check($sformatf("rnd%0d d%0d cnt", t, k), ac, CNT_EN ? m[k].cnt : 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PAT_W, default 3: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN, default 3'b101 (PAT_W bits): target sequence; PATTERN[PAT_W-1] is the first bit received.
REQ-003 SHALL have parameter OVERLAP, default 1: 1 = overlapping matches, 0 = non-overlapping.
REQ-004 SHALL have parameter CNT_W, default 8: match counter width, legal range 1..32.
REQ-005 SHALL have port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port Clr, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port X, input, 1 bit: serial data bit.
REQ-008 SHALL have port X_vld, input, 1 bit: X is consumed only on edges where X_vld=1.
REQ-009 SHALL have port Z, output, 1 bit: Moore match flag, high while progress == PAT_W.
REQ-010 SHALL have port prog, output, $clog2(PAT_W+1) bits: current count of matched pattern bits.
REQ-011 SHALL have port match_cnt, output, CNT_W bits: number of completed matches.

Function
REQ-012 SHALL hold progress state P in 0..PAT_W; P=k means the last k consumed bits equal the first k bits of PATTERN.
REQ-013 SHALL, on an edge with X_vld=1 and P<PAT_W, set P to the longest j<=P+1 such that the first j pattern bits equal a suffix of (first P pattern bits followed by X) (KMP failure rule).
REQ-014 SHALL, with OVERLAP=1 and P==PAT_W, apply the REQ-013 rule with P taken as PAT_W (pattern is its own prefix source).
REQ-015 SHALL, with OVERLAP=0 and P==PAT_W, treat the transition as from P=0.
REQ-016 SHALL hold P, Z and match_cnt unchanged on edges with X_vld=0.
REQ-017 SHALL drive Z = (P==PAT_W) from the registered state, no combinational path from X or X_vld; Z is therefore high in the cycle after the completing bit and stays high until the next consumed bit.
REQ-018 SHALL increment match_cnt by 1 on each edge where P transitions into PAT_W, including PAT_W->PAT_W re-entry (e.g. all-ones pattern, overlapping).
REQ-019 SHALL saturate match_cnt at 2^CNT_W-1; no wrap-around.
REQ-020 SHALL compute the next-state table at elaboration time from PATTERN, PAT_W and OVERLAP; no runtime pattern programming.
REQ-021 SHALL produce an elaboration error for PAT_W outside 2..16 or CNT_W outside 1..32.

Reset
REQ-022 SHALL, on an edge with Clr=1, set P=0, Z=0 and match_cnt=0, overriding X_vld, including mid-pattern and while Z=1.
REQ-023 SHALL contain no initial blocks and no asynchronous reset path; the first edge with Clr=1 defines all state.

Configuration
REQ-024 SHALL, with macro SEQDET_MATCH_CNT_EN defined, implement match_cnt per REQ-018/019.
REQ-025 SHALL, with SEQDET_MATCH_CNT_EN undefined, tie match_cnt to 0 and infer no counter flops; all other behaviour is unchanged.

Structure
REQ-026 SHALL place in package seq_detect_pkg: the parameter range limits (PAT_W_MIN=2, PAT_W_MAX=16), and a constant function computing next-state from (P, X, PATTERN, PAT_W, OVERLAP).
REQ-027 SHALL use one sub-module, seq_match_cnt (saturating, enable-gated counter), instantiated only under SEQDET_MATCH_CNT_EN.

Verification
REQ-028 SHALL test PAT_W=3, PATTERN=101, OVERLAP=1 with X=1,0,1,0,1 (X_vld=1 each cycle) -> Z high after bits 3 and 5, match_cnt=2.
REQ-029 SHALL test the same stream with OVERLAP=0 -> Z high only after bit 3, match_cnt=1; P=0 after bit 4 and P=1 after bit 5.
REQ-030 SHALL test PAT_W=6, PATTERN=101101, OVERLAP=1 with stream 1,0,1,1,0,1,1,0,1 -> Z high after bits 6 and 9, match_cnt=2.
REQ-031 SHALL test X_vld=0 for 3 cycles inserted between bits 2 and 3 of 101 -> P holds at 2, Z rises after the delayed bit 3, and Z stays high while X_vld=0 afterwards.
REQ-032 SHALL test Clr=1 asserted with P=2, then while Z=1 -> next edge gives P=0, Z=0, match_cnt=0, and a following 1,0,1 matches normally.
REQ-033 SHALL test CNT_W=2 with PATTERN=11 (PAT_W=2), OVERLAP=1, and six 1s -> match_cnt=1,2,3,3,3 and Z held high from bit 2 onward.
